// File: rtl/secure_reg_write_ctrl_if.sv
// Session/entry/strobe bundle between the password-gated write controller and its user.
interface secure_reg_write_ctrl_if #(
  parameter int KEY_W    = 8,
  parameter int NUM_REGS = 2
);
  logic                request;
  logic                confirm;
  logic [KEY_W-1:0]    password;
  logic [KEY_W-1:0]    key;
  logic [NUM_REGS-1:0] write_en;
  logic [KEY_W-1:0]    write_data;
  logic                error;
  logic                locked;
  logic [2:0]          state_o;

  modport master (
    output request, confirm, password, key,
    input  write_en, write_data, error, locked, state_o
  );

  modport slave (
    input  request, confirm, password, key,
    output write_en, write_data, error, locked, state_o
  );
endinterface

// File: rtl/secure_reg_write_ctrl.sv
// Password-gated register write controller with retry limit and timed lockout.
// Optional FAIL_AUDIT_EN adds a saturating wrong-password counter port fail_total.
module secure_reg_write_ctrl #(
  parameter int KEY_W       = 8,
  parameter int NUM_REGS    = 2,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  secure_reg_write_ctrl_if.slave bus
`ifdef FAIL_AUDIT_EN
  ,
  output logic [15:0]           fail_total
`endif
);

  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  localparam int LT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MAX_TRIES_C = CNT_W'(MAX_TRIES);
  localparam logic [LT_W-1:0]  LOCK_INIT   = LT_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_REGS_C  = (SEL_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_DISABLE = 3'b000,
    S_ACTIVE  = 3'b001,
    S_AUTH    = 3'b101,
    S_ERROR   = 3'b111,
    S_WRITE   = 3'b110,
    S_LOCKED  = 3'b010
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d, fail_inc;
  logic [LT_W-1:0]     lock_timer_q, lock_timer_d;
  logic                confirm_q, confirm_d;
  logic [NUM_REGS-1:0] write_en_q, write_en_d;
  logic [KEY_W-1:0]    write_data_q, write_data_d;
  logic                error_q, error_d;
  logic                locked_q, locked_d;
  logic                cpulse, key_ok;
  logic [SEL_W-1:0]    sel;

  assign cpulse = bus.confirm & ~confirm_q;
  assign key_ok = (bus.key == bus.password);
  assign sel    = bus.key[KEY_W-1 -: SEL_W];

  always_comb begin
    state_d      = state_q;
    fail_cnt_d   = fail_cnt_q;
    lock_timer_d = lock_timer_q;
    write_en_d   = '0;
    write_data_d = write_data_q;
    confirm_d    = bus.confirm;
    fail_inc     = fail_cnt_q + 1'b1;

    case (state_q)
      S_DISABLE: if (bus.request) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (!bus.request) begin
          state_d = S_DISABLE;
        end else if (cpulse) begin
          if (key_ok) begin
            state_d    = S_AUTH;
            fail_cnt_d = '0;
          end else if (fail_inc == MAX_TRIES_C) begin
            state_d      = S_LOCKED;
            lock_timer_d = LOCK_INIT;
            fail_cnt_d   = '0;
          end else begin
            state_d    = S_ERROR;
            fail_cnt_d = fail_inc;
          end
        end
      end
      S_AUTH: begin
        if (!bus.request) begin
          state_d = S_DISABLE;
        end else if (cpulse && !key_ok) begin
          // Selectors past NUM_REGS only exist when NUM_REGS is not a power of two.
          if ({1'b0, sel} < NUM_REGS_C) begin
            state_d      = S_WRITE;
            write_en_d   = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel;
            write_data_d = bus.key;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: if (!bus.request) state_d = S_DISABLE;
      S_WRITE: state_d = bus.request ? S_AUTH : S_DISABLE;
      S_LOCKED: begin
        if (lock_timer_q == '0) state_d = S_DISABLE;
        else                    lock_timer_d = lock_timer_q - 1'b1;
      end
      default: state_d = S_DISABLE;
    endcase

    error_d  = (state_d == S_ERROR);
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_DISABLE;
      fail_cnt_q   <= '0;
      lock_timer_q <= '0;
      confirm_q    <= 1'b0;
      write_en_q   <= '0;
      write_data_q <= '0;
      error_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_timer_q <= lock_timer_d;
      confirm_q    <= confirm_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      error_q      <= error_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.write_en   = write_en_q;
  assign bus.write_data = write_data_q;
  assign bus.error      = error_q;
  assign bus.locked     = locked_q;
  assign bus.state_o    = state_q;

`ifdef FAIL_AUDIT_EN
  logic [15:0] fail_total_q, fail_total_d;

  always_comb begin
    fail_total_d = fail_total_q;
    if (state_q == S_ACTIVE && bus.request && cpulse && !key_ok && fail_total_q != 16'hFFFF)
      fail_total_d = fail_total_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) fail_total_q <= '0;
    else       fail_total_q <= fail_total_d;
  end

  assign fail_total = fail_total_q;
`endif

endmodule

// File: tb/tb_secure_reg_write_ctrl.sv
// Scoreboard bench for secure_reg_write_ctrl: expected state transitions are queued, a monitor checks them.
module tb_secure_reg_write_ctrl;
  localparam logic [2:0] S_DIS  = 3'b000, S_ACT = 3'b001, S_AUTH = 3'b101;
  localparam logic [2:0] S_ERR  = 3'b111, S_WR  = 3'b110, S_LCK  = 3'b010;
  localparam logic [7:0] PWD    = 8'hA5;

  typedef struct {
    logic [2:0] st;
    logic [1:0] we;
    logic [7:0] wd;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  secure_reg_write_ctrl_if #(.KEY_W(8), .NUM_REGS(2)) bus ();
`ifdef FAIL_AUDIT_EN
  logic [15:0] fail_total;
`endif

  secure_reg_write_ctrl #(
    .KEY_W(8), .NUM_REGS(2), .MAX_TRIES(3), .LOCK_CYCLES(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FAIL_AUDIT_EN
    ,
    .fail_total (fail_total)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] we, input logic [7:0] wd);
    exp_t e;
    e.st = st; e.we = we; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [7:0] k);
    bus.key = k;
    bus.confirm = 1'b1;
    tick();
    bus.confirm = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    int n = 0;
    while (bus.state_o !== target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", {29'd0, bus.state_o}, {29'd0, target});
  endtask

  // Three wrong entries from a clean retry count; the third must lock.
  task automatic three_wrong(input logic [7:0] k0, input logic [7:0] wd);
    for (int i = 0; i < 3; i++) begin
      push(S_ACT, 2'b00, wd);
      bus.request = 1'b1;
      tick();
      push((i == 2) ? S_LCK : S_ERR, 2'b00, wd);
      pulse(k0 + 8'(i));
      if (i < 2) begin
        push(S_DIS, 2'b00, wd);
        bus.request = 1'b0;
        tick();
      end
    end
  endtask

  // Monitor: each state change pops one expectation; lockout length measured independently.
  logic [2:0] prev_st;
  int         dwell = 0;
  logic       rst_seen = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (bus.state_o !== prev_st) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transition", {29'd0, bus.state_o}, {29'd0, prev_st});
        end else begin
          e = exp_q.pop_front();
          chk("state",      {29'd0, bus.state_o},  {29'd0, e.st});
          chk("write_en",   {30'd0, bus.write_en}, {30'd0, e.we});
          chk("write_data", {24'd0, bus.write_data}, {24'd0, e.wd});
          chk("error",      {31'd0, bus.error},  {31'd0, (e.st == S_ERR)});
          chk("locked",     {31'd0, bus.locked}, {31'd0, (e.st == S_LCK)});
        end
        if (prev_st == S_LCK && !rst_seen) chk("lock_dwell", dwell, 16);
        if (bus.state_o == S_LCK) rst_seen = 1'b0;
        dwell = 0;
      end
      if (bus.state_o == S_LCK) dwell++;
      if (bus.state_o != S_WR) chk("strobe_idle", {30'd0, bus.write_en}, 32'd0);
      if (reset) rst_seen = 1'b1;
      prev_st = bus.state_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.request  = 1'b0;
    bus.confirm  = 1'b0;
    bus.key      = 8'h00;
    bus.password = PWD;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_state",      {29'd0, bus.state_o},   32'd0);
    chk("rst_write_en",   {30'd0, bus.write_en},  32'd0);
    chk("rst_write_data", {24'd0, bus.write_data}, 32'd0);
    chk("rst_error",      {31'd0, bus.error},     32'd0);
    chk("rst_locked",     {31'd0, bus.locked},    32'd0);
    reset = 1'b0;
    prev_st = bus.state_o;
    mon_en = 1'b1;

    // 1: open, authenticate, write P
    push(S_ACT, 2'b00, 8'h00);
    bus.request = 1'b1;
    tick();
    push(S_AUTH, 2'b00, 8'h00);
    pulse(PWD);
    push(S_WR,   2'b01, 8'h3C);
    push(S_AUTH, 2'b00, 8'h3C);
    pulse(8'h3C);

    // 2: held confirm writes once to Q, then a fresh edge writes P
    push(S_WR,   2'b10, 8'h9E);
    push(S_AUTH, 2'b00, 8'h9E);
    bus.key = 8'h9E;
    bus.confirm = 1'b1;
    repeat (5) tick();
    bus.confirm = 1'b0;
    tick();
    push(S_WR,   2'b01, 8'h11);
    push(S_AUTH, 2'b00, 8'h11);
    pulse(8'h11);

    // 3: wrong password -> ERROR, confirms ignored, drop exits
    push(S_DIS, 2'b00, 8'h11);
    bus.request = 1'b0;
    tick();
    push(S_ACT, 2'b00, 8'h11);
    bus.request = 1'b1;
    tick();
    push(S_ERR, 2'b00, 8'h11);
    pulse(8'h00);
    chk("error_level", {31'd0, bus.error}, 32'd1);
    pulse(PWD);
    pulse(8'h00);
    push(S_DIS, 2'b00, 8'h11);
    bus.request = 1'b0;
    tick();
    chk("error_cleared", {31'd0, bus.error}, 32'd0);

    // 4: clear retry count with a good login, then three wrong entries lock for 16 cycles
    push(S_ACT, 2'b00, 8'h11);
    bus.request = 1'b1;
    tick();
    push(S_AUTH, 2'b00, 8'h11);
    pulse(PWD);
    push(S_DIS, 2'b00, 8'h11);
    bus.request = 1'b0;
    tick();
    three_wrong(8'h10, 8'h11);
    chk("locked_level", {31'd0, bus.locked}, 32'd1);
    bus.key = PWD;
    for (int i = 0; i < 10; i++) begin
      bus.confirm = ~bus.confirm;
      tick();
    end
    bus.confirm = 1'b0;
    bus.request = 1'b0;
    push(S_DIS, 2'b00, 8'h11);
    wait_state(S_DIS, 20);
    chk("locked_cleared", {31'd0, bus.locked}, 32'd0);
`ifdef FAIL_AUDIT_EN
    chk("fail_total_after_lock", {16'd0, fail_total}, 32'd4);
`endif
    push(S_ACT, 2'b00, 8'h11);
    bus.request = 1'b1;
    tick();
    push(S_AUTH, 2'b00, 8'h11);
    pulse(PWD);

    // 5a: request falls with the data confirm -> no write
    push(S_DIS, 2'b00, 8'h11);
    bus.key = 8'h3C;
    bus.confirm = 1'b1;
    bus.request = 1'b0;
    tick();
    bus.confirm = 1'b0;
    tick();
    // 5b: request falls during WRITE -> strobe kept, then DISABLE
    push(S_ACT, 2'b00, 8'h11);
    bus.request = 1'b1;
    tick();
    push(S_AUTH, 2'b00, 8'h11);
    pulse(PWD);
    push(S_WR,  2'b10, 8'hC7);
    push(S_DIS, 2'b00, 8'hC7);
    bus.key = 8'hC7;
    bus.confirm = 1'b1;
    tick();
    bus.request = 1'b0;
    bus.confirm = 1'b0;
    tick();

    // 6: reset in the middle of a lockout
    three_wrong(8'h20, 8'hC7);
    repeat (7) tick();
`ifdef FAIL_AUDIT_EN
    chk("fail_total_before_reset", {16'd0, fail_total}, 32'd7);
`endif
    push(S_DIS, 2'b00, 8'h00);
    reset = 1'b1;
    bus.request = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_lock_rst_state",  {29'd0, bus.state_o},    32'd0);
    chk("mid_lock_rst_locked", {31'd0, bus.locked},     32'd0);
    chk("mid_lock_rst_we",     {30'd0, bus.write_en},   32'd0);
    chk("mid_lock_rst_wd",     {24'd0, bus.write_data}, 32'd0);
    chk("mid_lock_rst_error",  {31'd0, bus.error},      32'd0);
`ifdef FAIL_AUDIT_EN
    chk("fail_total_after_reset", {16'd0, fail_total}, 32'd0);
`endif
    repeat (20) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
